ground_scroll_ctrl: RTL and testbench



---
 rtl/dino_pkg.sv | 32 +++
 rtl/ground_speed_ramp.sv | 53 +++++
 rtl/ground_scroll_ctrl.sv | 153 +++++++++++++++
 tb/tb_ground_scroll_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and widths for the ground/obstacle scroll sequencer.
// GROUND_SCROLL_PAUSE_EN adds the PAUSE state to the game state enum.
package dino_pkg;

  localparam int GROUND_WRAP = 160;
  localparam int POS_W       = 10;
  localparam int SPEED_W     = 4;
  localparam int SCORE_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    OVER  = 2'd2
`ifdef GROUND_SCROLL_PAUSE_EN
    , PAUSE = 2'd3
`endif
  } game_state_e;

  // Advance a scroll offset by one frame; the sum never reaches 2*wrap,
  // so a single conditional subtract is enough.
  function automatic logic [POS_W-1:0] wrap_add(input logic [POS_W-1:0]   pos,
                                                input logic [SPEED_W-1:0] spd,
                                                input logic [POS_W:0]     wrap);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + {{(POS_W + 1 - SPEED_W){1'b0}}, spd};
    if (sum >= wrap) begin
      sum = sum - wrap;
    end
    return sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/ground_speed_ramp.sv
// Scroll speed register with a per-frame ramp counter; speed steps up once
// every RAMP_FRAMES advances and saturates at SPEED_MAX.
module ground_speed_ramp
  import dino_pkg::*;
#(
  parameter int SPEED_INIT  = 3,
  parameter int SPEED_MAX   = 12,
  parameter int RAMP_FRAMES = 600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  output logic [SPEED_W-1:0] speed
);

  localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [SPEED_W-1:0] SPD_INIT  = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);

  logic [RAMP_W-1:0]  ramp_q, ramp_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  always_comb begin
    ramp_d  = ramp_q;
    speed_d = speed_q;
    if (load) begin
      ramp_d  = '0;
      speed_d = SPD_INIT;
    end else if (advance) begin
      if (ramp_q == RAMP_LAST) begin
        ramp_d  = '0;
        speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 1'b1;
      end else begin
        ramp_d = ramp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ramp_q  <= '0;
      speed_q <= SPD_INIT;
    end else begin
      ramp_q  <= ramp_d;
      speed_q <= speed_d;
    end
  end

  assign speed = speed_q;

endmodule

// File: rtl/ground_scroll_ctrl.sv
// Game sequencer: IDLE/RUN/OVER FSM driving scroll offset, speed and score,
// all advancing on frame_tick. GROUND_SCROLL_PAUSE_EN adds a pause input and PAUSE state.
module ground_scroll_ctrl
  import dino_pkg::*;
#(
  parameter int WRAP        = GROUND_WRAP,
  parameter int SPEED_INIT  = 3,
  parameter int SPEED_MAX   = 12,
  parameter int RAMP_FRAMES = 600,
  parameter int OVER_HOLD   = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               collision,
`ifdef GROUND_SCROLL_PAUSE_EN
  input  logic               pause,
`endif
  output logic               game_status,
  output logic               over,
  output logic [SPEED_W-1:0] speed,
  output logic [POS_W-1:0]   ground_position,
  output logic [SCORE_W-1:0] score
);

  localparam int HOLD_W = $clog2(OVER_HOLD + 1);
  localparam logic [POS_W:0]    WRAP_C = (POS_W + 1)'(WRAP);
  localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(OVER_HOLD);

  game_state_e        state_q, state_d;
  logic               start_q;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               game_status_q, game_status_d;
  logic               over_q, over_d;
  logic               start_edge;
  logic               load;
  logic               advance;

`ifdef GROUND_SCROLL_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = pause & ~pause_q;
`endif

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    score_d = score_q;
    hold_d  = hold_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        load    = 1'b1;
        pos_d   = '0;
        score_d = '0;
        if (start_edge) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Collision wins over a coincident frame_tick: the frame is not scored.
        if (collision) begin
          state_d = OVER;
          hold_d  = '0;
        end
`ifdef GROUND_SCROLL_PAUSE_EN
        else if (pause_edge) begin
          state_d = PAUSE;
        end
`endif
        else if (frame_tick) begin
          pos_d   = wrap_add(pos_q, speed, WRAP_C);
          score_d = (score_q == '1) ? score_q : score_q + 1'b1;
          advance = 1'b1;
        end
      end
      OVER: begin
        if (start_edge && (hold_q == HOLD_C)) begin
          state_d = RUN;
          load    = 1'b1;
          pos_d   = '0;
          score_d = '0;
        end else if (frame_tick && (hold_q != HOLD_C)) begin
          hold_d = hold_q + 1'b1;
        end
      end
`ifdef GROUND_SCROLL_PAUSE_EN
      PAUSE: begin
        if (pause_edge) begin
          state_d = RUN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    game_status_d = (state_d == RUN);
    over_d        = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      start_q       <= 1'b1;
      pos_q         <= '0;
      score_q       <= '0;
      hold_q        <= '0;
      game_status_q <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      pos_q         <= pos_d;
      score_q       <= score_d;
      hold_q        <= hold_d;
      game_status_q <= game_status_d;
      over_q        <= over_d;
    end
  end

`ifdef GROUND_SCROLL_PAUSE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pause_q <= 1'b1;
    end else begin
      pause_q <= pause;
    end
  end
`endif

  ground_speed_ramp #(
    .SPEED_INIT (SPEED_INIT),
    .SPEED_MAX  (SPEED_MAX),
    .RAMP_FRAMES(RAMP_FRAMES)
  ) u_speed_ramp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .advance(advance),
    .speed  (speed)
  );

  assign game_status     = game_status_q;
  assign over            = over_q;
  assign ground_position = pos_q;
  assign score           = score_q;

endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// Bench for ground_scroll_ctrl: two instances (default timing, and a short
// ramp/hold variant) share stimulus and are checked against a frame-count model.
module tb_ground_scroll_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic start = 1'b1;
  logic collision = 1'b0;

  logic        gs_a, ov_a, gs_b, ov_b;
  logic [3:0]  sp_a, sp_b;
  logic [9:0]  pos_a, pos_b;
  logic [15:0] sc_a, sc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ground_scroll_ctrl #(
    .WRAP(160), .SPEED_INIT(3), .SPEED_MAX(12), .RAMP_FRAMES(600), .OVER_HOLD(60)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .collision(collision),
`ifdef GROUND_SCROLL_PAUSE_EN
    .pause(1'b0),
`endif
    .game_status(gs_a), .over(ov_a), .speed(sp_a), .ground_position(pos_a), .score(sc_a)
  );

  ground_scroll_ctrl #(
    .WRAP(160), .SPEED_INIT(3), .SPEED_MAX(5), .RAMP_FRAMES(4), .OVER_HOLD(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .collision(collision),
`ifdef GROUND_SCROLL_PAUSE_EN
    .pause(1'b0),
`endif
    .game_status(gs_b), .over(ov_b), .speed(sp_b), .ground_position(pos_b), .score(sc_b)
  );

  // Model: a game is just "frames survived"; speed and score follow from it.
  function automatic int p_max(input int i);
    return (i == 0) ? 12 : 5;
  endfunction
  function automatic int p_ramp(input int i);
    return (i == 0) ? 600 : 4;
  endfunction
  function automatic int p_hold(input int i);
    return (i == 0) ? 60 : 3;
  endfunction

  int  m_mode [2];   // 0 idle, 1 running, 2 game over
  int  m_frames [2];
  int  m_pos [2];
  int  m_hold [2];
  bit  m_sprev = 1'b1;
  bit  m_valid = 1'b0;

  function automatic int m_speed(input int i);
    int s;
    s = 3 + m_frames[i] / p_ramp(i);
    return (s > p_max(i)) ? p_max(i) : s;
  endfunction

  always @(posedge clk) begin
    bit sedge;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_frames[i] = 0; m_pos[i] = 0; m_hold[i] = 0;
      end
      m_sprev = 1'b1;
      m_valid = 1'b1;
    end else begin
      sedge = start && !m_sprev;
      m_sprev = start;
      for (int i = 0; i < 2; i++) begin
        case (m_mode[i])
          0: if (sedge) begin m_mode[i] = 1; m_frames[i] = 0; m_pos[i] = 0; end
          1: begin
            if (collision) begin
              m_mode[i] = 2; m_hold[i] = 0;
            end else if (frame_tick) begin
              m_pos[i] = (m_pos[i] + m_speed(i)) % 160;
              m_frames[i]++;
            end
          end
          default: begin
            if (sedge && m_hold[i] == p_hold(i)) begin
              m_mode[i] = 1; m_frames[i] = 0; m_pos[i] = 0;
            end else if (frame_tick && m_hold[i] < p_hold(i)) begin
              m_hold[i]++;
            end
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic gs, input logic ov, input logic [3:0] sp,
                          input logic [9:0] pos, input logic [15:0] sc);
    int exp_sc;
    exp_sc = (m_frames[i] > 65535) ? 65535 : m_frames[i];
    check($sformatf("model%0d.game_status", i), int'(gs), int'(m_mode[i] == 1));
    check($sformatf("model%0d.over", i), int'(ov), int'(m_mode[i] == 2));
    check($sformatf("model%0d.speed", i), int'(sp), m_speed(i));
    check($sformatf("model%0d.position", i), int'(pos), m_pos[i]);
    check($sformatf("model%0d.score", i), int'(sc), exp_sc);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_inst(0, gs_a, ov_a, sp_a, pos_a, sc_a);
      cmp_inst(1, gs_b, ov_b, sp_b, pos_b, sc_b);
    end
  end

  // Inputs change 2 time units after a rising edge; returning here means the
  // edge that sampled them has been taken.
  task automatic apply(input logic ft, input logic col, input logic st);
    frame_tick = ft;
    collision  = col;
    start      = st;
    @(posedge clk);
    #2;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      apply(1'b1, 1'b0, start);
      apply(1'b0, 1'b0, start);
    end
  endtask

  initial begin
    @(posedge clk);
    #2;
    // Held start through reset is not a start.
    rst_n = 1'b0;
    repeat (3) apply(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    do_ticks(5);
    check("held_start.a.game_status", int'(gs_a), 0);
    check("held_start.a.position", int'(pos_a), 0);
    check("held_start.a.speed", int'(sp_a), 3);
    check("held_start.a.score", int'(sc_a), 0);
    check("held_start.b.game_status", int'(gs_b), 0);

    // Start, ramp on B, wrap on A.
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1);
    check("start.a.game_status", int'(gs_a), 1);
    for (int t = 1; t <= 54; t++) begin
      do_ticks(1);
      if (t == 4)  check("ramp.b.speed_t4", int'(sp_b), 4);
      if (t == 8)  check("ramp.b.speed_t8", int'(sp_b), 5);
      if (t == 12) check("ramp.b.speed_t12", int'(sp_b), 5);
      if (t == 53) check("wrap.a.pos_t53", int'(pos_a), 159);
    end
    check("wrap.a.pos_t54", int'(pos_a), 2);
    check("wrap.a.score", int'(sc_a), 54);
    check("wrap.a.speed", int'(sp_a), 3);
    check("wrap.a.game_status", int'(gs_a), 1);

    // Collision, then restart hold on B.
    apply(1'b0, 1'b1, 1'b1);
    check("collide.a.over", int'(ov_a), 1);
    check("collide.a.pos", int'(pos_a), 2);
    start = 1'b0;
    do_ticks(2);
    apply(1'b0, 1'b0, 1'b1);
    check("hold.b.early_start_ignored", int'(ov_b), 1);
    start = 1'b0;
    do_ticks(1);
    apply(1'b0, 1'b0, 1'b1);
    check("hold.b.restart_gs", int'(gs_b), 1);
    check("hold.b.restart_pos", int'(pos_b), 0);
    check("hold.b.restart_speed", int'(sp_b), 3);
    check("hold.b.restart_score", int'(sc_b), 0);
    check("hold.a.still_over", int'(ov_a), 1);

    // A: finish its hold, restart, reach position 30, collide on a tick.
    start = 1'b0;
    do_ticks(57);
    apply(1'b0, 1'b0, 1'b1);
    check("restart.a.game_status", int'(gs_a), 1);
    do_ticks(10);
    check("pos30.a.pos", int'(pos_a), 30);
    apply(1'b1, 1'b1, start);
    check("coll_tick.a.over", int'(ov_a), 1);
    check("coll_tick.a.pos", int'(pos_a), 30);
    check("coll_tick.a.score", int'(sc_a), 10);
    do_ticks(3);
    check("frozen.a.pos", int'(pos_a), 30);
    check("frozen.a.score", int'(sc_a), 10);
    check("frozen.a.speed", int'(sp_a), 3);

    // B: restart, run 9 frames, then reset mid-game.
    start = 1'b0;
    do_ticks(3);
    apply(1'b0, 1'b0, 1'b1);
    do_ticks(9);
    check("midrun.b.pos", int'(pos_b), 33);
    check("midrun.b.speed", int'(sp_b), 5);
    rst_n = 1'b0;
    apply(1'b0, 1'b0, start);
    rst_n = 1'b1;
    check("midreset.b.game_status", int'(gs_b), 0);
    check("midreset.b.pos", int'(pos_b), 0);
    check("midreset.b.speed", int'(sp_b), 3);
    check("midreset.b.score", int'(sc_b), 0);

    // Random traffic against the model.
    for (int c = 0; c < 5000; c++) begin
      logic ft, col, st;
      rst_n = ($urandom_range(0, 1499) != 0);
      ft    = ($urandom_range(0, 2) == 0);
      col   = ($urandom_range(0, 199) == 0);
      st    = start;
      if ($urandom_range(0, 7) == 0) st = ~st;
      apply(ft, col, st);
    end
    rst_n = 1'b1;
    apply(1'b0, 1'b0, start);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
